// File: rtl/darth_pkg.sv
`default_nettype none
// ============================================================================
// Package     : darth_pkg
// Description : Shared types and constants for the push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package darth_pkg;

  // Samples a new level must stay stable before it is accepted
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Per-channel debounce state; the accepted level is 1 in HIGH and FALL_PEND
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } deb_state_t;

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One-bit debouncer: two-flop synchronizer, 4-state FSM and a
//               saturating-free stability counter.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import darth_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // The D-th consecutive stable sample arrives while the counter holds D-1,
  // so the level flips on that sample and the counter never passes D-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             sync_meta;
  logic             sync_out;
  deb_state_t       state;
  deb_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic; any sample disagreeing with a pending
  // change aborts it and returns to the stable state with the counter cleared
  always_comb begin
    state_next = state;
    cnt_next   = CNT_ZERO;
    unique case (state)
      LOW: begin
        if (sync_out) begin
          state_next = RISE_PEND;
          cnt_next   = CNT_ONE;
        end
      end
      RISE_PEND: begin
        if (!sync_out) begin
          state_next = LOW;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (!sync_out) begin
          state_next = FALL_PEND;
          cnt_next   = CNT_ONE;
        end
      end
      FALL_PEND: begin
        if (sync_out) begin
          state_next = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
      end
    endcase
  end

  assign level = (state == HIGH) || (state == FALL_PEND);

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Debounces the four game push-buttons, makes left/right
//               mutually exclusive and turns fire into a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
  import darth_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_ship,
  input  logic rst_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_fire,
  input  logic btn_reset,
  output logic d_left,
  output logic d_right,
  output logic d_fire,
  output logic d_reset
);

  localparam int NUM_CH = 4;
  localparam int CH_LEFT  = 0;
  localparam int CH_RIGHT = 1;
  localparam int CH_FIRE  = 2;
  localparam int CH_RESET = 3;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] level;
  logic              fire_lvl;
  logic              fire_lvl_d;

  assign raw = {btn_reset, btn_fire, btn_right, btn_left};

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk  (clk_ship),
        .rst_n(rst_n),
        .raw  (raw[i]),
        .level(level[i])
      );
    end
  endgenerate

  // Registered outputs; the fire level is registered like the others and its
  // rising edge then produces the pulse one cycle later
  always_ff @(posedge clk_ship or negedge rst_n) begin
    if (!rst_n) begin
      d_left     <= 1'b0;
      d_right    <= 1'b0;
      d_reset    <= 1'b0;
      d_fire     <= 1'b0;
      fire_lvl   <= 1'b0;
      fire_lvl_d <= 1'b0;
    end else begin
      d_left     <= level[CH_LEFT]  & ~level[CH_RIGHT];
      d_right    <= level[CH_RIGHT] & ~level[CH_LEFT];
      d_reset    <= level[CH_RESET];
      fire_lvl   <= level[CH_FIRE];
      fire_lvl_d <= fire_lvl;
      d_fire     <= fire_lvl & ~fire_lvl_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4)
//               against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  localparam int D = 4;

  logic clk_ship = 1'b0;
  logic rst_n    = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0, btn_reset = 1'b0;
  logic d_left, d_right, d_fire, d_reset;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per channel, raw values of the two previous edges,
  // accepted level, run length of samples disagreeing with it, and the
  // accepted level after each of the last three edges.
  logic [3:0] raw_p1, raw_p2, lvl, l1, l2, l3;
  int         run [4];
  logic       exp_left, exp_right, exp_fire, exp_reset;

  button_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_ship (clk_ship),
    .rst_n    (rst_n),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_fire (btn_fire),
    .btn_reset(btn_reset),
    .d_left   (d_left),
    .d_right  (d_right),
    .d_fire   (d_fire),
    .d_reset  (d_reset)
  );

  always #5 clk_ship = ~clk_ship;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_p1 = '0; raw_p2 = '0; lvl = '0; l1 = '0; l2 = '0; l3 = '0;
    for (int c = 0; c < 4; c++) run[c] = 0;
    exp_left = 0; exp_right = 0; exp_fire = 0; exp_reset = 0;
  endtask

  // Advance the model by one rising edge with raw inputs b present at it
  task automatic model_edge(input logic [3:0] b);
    if (!rst_n) begin
      model_reset();
      return;
    end
    exp_left  = l1[0] & ~l1[1];
    exp_right = l1[1] & ~l1[0];
    exp_reset = l1[3];
    exp_fire  = l2[2] & ~l3[2];
    for (int c = 0; c < 4; c++) begin
      // the value the debouncer sees now is the raw level two edges ago
      if (raw_p2[c] != lvl[c]) run[c]++;
      else                     run[c] = 0;
      if (run[c] == D) begin
        lvl[c] = ~lvl[c];
        run[c] = 0;
      end
    end
    raw_p2 = raw_p1;
    raw_p1 = b;
    l3 = l2; l2 = l1; l1 = lvl;
  endtask

  task automatic check_outputs();
    check_eq("d_left",  {31'd0, d_left},  {31'd0, exp_left});
    check_eq("d_right", {31'd0, d_right}, {31'd0, exp_right});
    check_eq("d_fire",  {31'd0, d_fire},  {31'd0, exp_fire});
    check_eq("d_reset", {31'd0, d_reset}, {31'd0, exp_reset});
  endtask

  // Drive buttons {reset,fire,right,left}, take one edge, check all outputs
  task automatic tick(input logic [3:0] b);
    {btn_reset, btn_fire, btn_right, btn_left} = b;
    @(posedge clk_ship);
    model_edge(b);
    #1;
    check_outputs();
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge
  task automatic async_reset(input int hold_edges);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int k = 0; k < hold_edges; k++) tick(4'($urandom_range(0, 15)));
    rst_n = 1'b1;
  endtask

  initial begin
    int first;
    int pulses;
    int hold [4];
    logic [3:0] b;

    model_reset();
    // Reset with toggling buttons, then release with buttons low
    #1;
    check_outputs();
    for (int k = 0; k < 8; k++) tick(4'($urandom_range(0, 15)));
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick(4'b0000);

    // Left held: rising latency, then falling latency
    first = -1;
    for (int k = 0; k < 12; k++) begin
      tick(4'b0001);
      if (d_left && first < 0) first = k;
    end
    check_eq("left_rise_edge", first, 6);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      tick(4'b0000);
      if (!d_left && first < 0) first = k;
    end
    check_eq("left_fall_edge", first, 6);

    // Right glitch of 3 cycles must never propagate
    pulses = 0;
    for (int k = 0; k < 3; k++)  begin tick(4'b0010); pulses += int'(d_right); end
    for (int k = 0; k < 12; k++) begin tick(4'b0000); pulses += int'(d_right); end
    check_eq("right_glitch_hi", pulses, 0);

    // Fire held for 100 cycles: one pulse, 7 edges after press
    first = -1; pulses = 0;
    for (int k = 0; k < 100; k++) begin
      tick(4'b0100);
      if (d_fire) begin pulses++; if (first < 0) first = k; end
    end
    check_eq("fire_pulse_cnt", pulses, 1);
    check_eq("fire_pulse_edge", first, 7);
    for (int k = 0; k < 12; k++) tick(4'b0000);

    // Both directions held: neither moves; releasing right frees left
    pulses = 0;
    for (int k = 0; k < 20; k++) begin tick(4'b0011); pulses += int'(d_left | d_right); end
    check_eq("both_held_out", pulses, 0);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      tick(4'b0001);
      if (d_left && first < 0) first = k;
    end
    check_eq("right_release_edge", first, 6);
    for (int k = 0; k < 12; k++) tick(4'b0000);

    // Game-reset held, rst_n pulsed mid-pending: full latency needed again
    for (int k = 0; k < 4; k++) tick(4'b1000);
    async_reset(1);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      tick(4'b1000);
      if (d_reset && first < 0) first = k;
    end
    check_eq("reset_btn_edge", first, 6);
    for (int k = 0; k < 12; k++) tick(4'b0000);

    // Random hold lengths around the debounce threshold, occasional resets
    for (int c = 0; c < 4; c++) hold[c] = 1;
    b = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < 4; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          b[c]    = ~b[c];
          hold[c] = int'($urandom_range(1, 9));
        end
      end
      if ($urandom_range(0, 499) == 0) async_reset(int'($urandom_range(0, 3)));
      tick(b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 50000, consecutive stable samples required to accept a new button level; legal range 2..2^20.
REQ-002 Port: clk_ship  input  1  game clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: btn_left  input  1  raw, asynchronous left push-button, active-high.
REQ-005 Port: btn_right  input  1  raw, asynchronous right push-button, active-high.
REQ-006 Port: btn_fire  input  1  raw, asynchronous fire push-button, active-high.
REQ-007 Port: btn_reset  input  1  raw, asynchronous game-reset push-button, active-high.
REQ-008 Port: d_left  output  1  debounced left level, qualified for ship movement.
REQ-009 Port: d_right  output  1  debounced right level, qualified for ship movement.
REQ-010 Port: d_fire  output  1  single-cycle pulse on each accepted fire press.
REQ-011 Port: d_reset  output  1  debounced game-reset level, active-high.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each channel SHALL run a 4-state FSM: LOW, RISE_PEND, HIGH, FALL_PEND.
REQ-014 LOW -> RISE_PEND when the synchronized sample is 1; counter loads 1.
REQ-015 RISE_PEND: sample 1 increments the counter; sample 0 returns to LOW with the counter cleared; when the counter reaches DEBOUNCE_CYCLES, go to HIGH and clear the counter.
REQ-016 HIGH/FALL_PEND SHALL mirror REQ-014/015 with the sample polarity inverted.
REQ-017 The channel's debounced level SHALL be 1 only in HIGH and FALL_PEND.
REQ-018 A raw change held stable SHALL appear on the debounced level exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled by the synchronizer.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no output change.
REQ-020 Counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits; the counter SHALL never wrap.
REQ-021 d_left = left level AND NOT right level; d_right = right level AND NOT left level. Both debounced high SHALL drive both outputs 0.
REQ-022 d_fire SHALL be 1 for exactly one cycle on the cycle after the fire level goes 0->1; holding fire SHALL NOT repeat the pulse.
REQ-023 d_reset SHALL equal the debounced reset level; it does not gate the other channels.
REQ-024 All outputs SHALL be registered; no combinational path from btn_* to d_*.

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force all synchronizers and counters to 0, all FSMs to LOW, and all outputs to 0.
REQ-026 rst_n asserted mid-debounce SHALL discard the pending transition; after release, a held button SHALL need the full DEBOUNCE_CYCLES+2 latency again.
REQ-027 rst_n deassertion is assumed synchronized upstream; first update is on the first rising edge with rst_n high.

Structure
REQ-028 Shared package darth_pkg SHALL hold the FSM state enum (LOW, RISE_PEND, HIGH, FALL_PEND) and the default DEBOUNCE_CYCLES constant.
REQ-029 One sub-module, debounce_channel (synchronizer + FSM + counter, one bit), SHALL be instantiated four times; the mutual-exclusion and fire-edge logic stay in the top.

Verification (DEBOUNCE_CYCLES=4 override)
REQ-030 rst_n=0, all btn_* toggling -> all d_* stay 0; release rst_n with buttons low -> d_* stay 0.
REQ-031 btn_left held 1 from edge 0 -> d_left rises at edge 6; release -> d_left falls 6 edges later.
REQ-032 btn_right pulsed high for 3 cycles, then low -> d_right never rises; the FSM returns to LOW.
REQ-033 btn_fire held 1 for 100 cycles -> d_fire high for exactly one cycle, 7 edges after press; no further pulses.
REQ-034 btn_left and btn_right both held -> d_left=d_right=0; release right -> d_left=1 six edges after the release is sampled.
REQ-035 btn_reset held, rst_n pulsed low at edge 4 (mid-pending) -> d_reset=0; after release, d_reset rises 6 edges later.
